// File: rtl/bp_me_cce_mem_mux.sv
// Merges per-CCE memory command channels onto one memory port and steers the
// in-order memory responses back to the CCE that issued each command.
module bp_me_cce_mem_mux #(
  parameter int num_cce_p         = 2,
  parameter int cmd_width_p       = 64,
  parameter int resp_width_p      = 64,
  parameter int max_outstanding_p = 4,
  parameter int rr_p              = 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_cce_p*cmd_width_p-1:0]     cmd_i,
  input  logic [num_cce_p-1:0]                 cmd_v_i,
  output logic [num_cce_p-1:0]                 cmd_yumi_o,
  output logic [cmd_width_p-1:0]               mem_cmd_o,
  output logic                                 mem_cmd_v_o,
  input  logic                                 mem_cmd_yumi_i,
  input  logic [resp_width_p-1:0]              mem_resp_i,
  input  logic                                 mem_resp_v_i,
  output logic                                 mem_resp_ready_o,
  output logic [num_cce_p*resp_width_p-1:0]    resp_o,
  output logic [num_cce_p-1:0]                 resp_v_o,
  input  logic [num_cce_p-1:0]                 resp_ready_i,
  output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
  output logic                                 error_o
);
  localparam int tag_w_lp = (num_cce_p > 1) ? $clog2(num_cce_p) : 1;
  localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int cnt_w_lp = $clog2(max_outstanding_p+1);

  // Handshakes: cmd_yumi_o/mem_cmd_yumi_i are same-cycle consumes of a valid
  // payload; a response transfers when mem_resp_v_i and mem_resp_ready_o are both high.
  logic                   reg_v_q, reg_v_d;
  logic [cmd_width_p-1:0] reg_data_q, reg_data_d;
  logic [cnt_w_lp-1:0]    count_q, count_d;
  logic [tag_w_lp-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ptr_w_lp-1:0]    head_q, head_d, tail_q, tail_d;
  logic                   error_q, error_d;
  logic [tag_w_lp-1:0]    tag_mem_q [max_outstanding_p];

  logic                   grant_found;
  logic [tag_w_lp-1:0]    grant_idx;
  logic [cmd_width_p-1:0] grant_data;
  logic                   accept, resp_fire, fifo_nonempty;
  logic [tag_w_lp-1:0]    head_tag;
  int                     arb_start;

  assign fifo_nonempty = (count_q != '0);
  assign head_tag      = tag_mem_q[head_q];

  // Search order starts at the round-robin pointer, or at channel 0 in fixed mode.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    arb_start   = (rr_p != 0) ? int'(rr_ptr_q) : 0;
    for (int i = 0; i < num_cce_p; i++) begin
      for (int j = 0; j < num_cce_p; j++) begin
        if (!grant_found && cmd_v_i[j] && (j == ((arb_start + i) % num_cce_p))) begin
          grant_found = 1'b1;
          grant_idx   = tag_w_lp'(j);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int j = 0; j < num_cce_p; j++) begin
      if (int'(grant_idx) == j) grant_data = cmd_i[j*cmd_width_p +: cmd_width_p];
    end
  end

  assign accept = !reset_i && (!reg_v_q || mem_cmd_yumi_i)
                  && (count_q < cnt_w_lp'(max_outstanding_p)) && grant_found;

  always_comb begin
    cmd_yumi_o = '0;
    for (int j = 0; j < num_cce_p; j++) begin
      cmd_yumi_o[j] = accept && (int'(grant_idx) == j);
    end
  end

  always_comb begin
    resp_v_o         = '0;
    mem_resp_ready_o = 1'b0;
    for (int j = 0; j < num_cce_p; j++) begin
      if (int'(head_tag) == j) begin
        resp_v_o[j]      = mem_resp_v_i && fifo_nonempty;
        mem_resp_ready_o = resp_ready_i[j] && fifo_nonempty;
      end
    end
  end

  assign resp_fire     = mem_resp_v_i && mem_resp_ready_o;
  assign resp_o        = {num_cce_p{mem_resp_i}};
  assign mem_cmd_v_o   = reg_v_q;
  assign mem_cmd_o     = reg_data_q;
  assign outstanding_o = count_q;
  assign error_o       = error_q;

  always_comb begin
    reg_v_d    = reg_v_q && !mem_cmd_yumi_i;
    reg_data_d = reg_data_q;
    rr_ptr_d   = rr_ptr_q;
    tail_d     = tail_q;
    head_d     = head_q;
    count_d    = count_q;
    error_d    = error_q || (mem_resp_v_i && !fifo_nonempty);
    if (accept) begin
      reg_v_d    = 1'b1;
      reg_data_d = grant_data;
      rr_ptr_d   = (int'(grant_idx) == num_cce_p-1) ? '0 : grant_idx + tag_w_lp'(1);
      tail_d     = (int'(tail_q) == max_outstanding_p-1) ? '0 : tail_q + ptr_w_lp'(1);
    end
    if (resp_fire) begin
      head_d = (int'(head_q) == max_outstanding_p-1) ? '0 : head_q + ptr_w_lp'(1);
    end
    if (accept && !resp_fire)      count_d = count_q + cnt_w_lp'(1);
    else if (!accept && resp_fire) count_d = count_q - cnt_w_lp'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      reg_v_q    <= 1'b0;
      reg_data_q <= '0;
      rr_ptr_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      reg_v_q    <= reg_v_d;
      reg_data_q <= reg_data_d;
      rr_ptr_q   <= rr_ptr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      error_q    <= error_d;
    end
  end

  // Tag storage needs no reset: occupancy is tracked by count_q and the pointers.
  always_ff @(posedge clk_i) begin
    if (accept) tag_mem_q[tail_q] <= grant_idx;
  end

endmodule

// File: tb/tb_bp_me_cce_mem_mux.sv
// Randomized and directed bench for bp_me_cce_mem_mux against a queue-based
// reference model; a second fixed-priority instance checks priority grants.
module tb_bp_me_cce_mem_mux;
  localparam int N   = 4;
  localparam int TW  = 2;
  localparam int CW  = 16;
  localparam int RW  = 16;
  localparam int MAX = 3;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  logic [N*CW-1:0] cmd;
  logic [N-1:0]    cmd_v, cmd_yumi;
  logic [CW-1:0]   mem_cmd;
  logic            mem_cmd_v, mem_cmd_yumi;
  logic [RW-1:0]   mem_resp;
  logic            mem_resp_v, mem_resp_ready;
  logic [N*RW-1:0] resp;
  logic [N-1:0]    resp_v, resp_ready;
  logic [1:0]      outstanding;
  logic            error;

  bp_me_cce_mem_mux #(.num_cce_p(N), .cmd_width_p(CW), .resp_width_p(RW),
                      .max_outstanding_p(MAX), .rr_p(1)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_i(cmd), .cmd_v_i(cmd_v), .cmd_yumi_o(cmd_yumi),
    .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_yumi_i(mem_cmd_yumi),
    .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_ready_o(mem_resp_ready),
    .resp_o(resp), .resp_v_o(resp_v), .resp_ready_i(resp_ready),
    .outstanding_o(outstanding), .error_o(error));

  logic [N*8-1:0] b_cmd;
  logic [N-1:0]   b_cmd_v, b_cmd_yumi, b_resp_v;
  logic [7:0]     b_mem_cmd;
  logic           b_mem_cmd_v, b_mem_resp_ready, b_error;
  logic [N*8-1:0] b_resp;
  logic [2:0]     b_outstanding;

  bp_me_cce_mem_mux #(.num_cce_p(N), .cmd_width_p(8), .resp_width_p(8),
                      .max_outstanding_p(4), .rr_p(0)) dut_fixed (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_i(b_cmd), .cmd_v_i(b_cmd_v), .cmd_yumi_o(b_cmd_yumi),
    .mem_cmd_o(b_mem_cmd), .mem_cmd_v_o(b_mem_cmd_v), .mem_cmd_yumi_i(b_mem_cmd_v),
    .mem_resp_i(8'h00), .mem_resp_v_i(1'b0), .mem_resp_ready_o(b_mem_resp_ready),
    .resp_o(b_resp), .resp_v_o(b_resp_v), .resp_ready_i({N{1'b0}}),
    .outstanding_o(b_outstanding), .error_o(b_error));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: issue order of tags, the output register, the rr pointer, sticky error.
  logic [TW-1:0] exp_q[$];
  bit            m_reg_v;
  logic [CW-1:0] m_reg_d;
  int            m_ptr;
  bit            m_err;

  task automatic model_reset();
    exp_q.delete();
    m_reg_v = 0;
    m_reg_d = '0;
    m_ptr   = 0;
    m_err   = 0;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic rv, input logic [N-1:0] rdy);
    cmd_v        = v;
    cmd          = {$urandom, $urandom};
    mem_cmd_yumi = m_reg_v;
    mem_resp_v   = rv;
    mem_resp     = RW'($urandom);
    resp_ready   = rdy;
  endtask

  // Called at a falling edge with inputs already driven; checks, then advances one clock.
  task automatic step();
    int w;
    logic [N-1:0] e_yumi, e_rv;
    logic e_rdy, fire;
    #1;
    w = -1;
    if (!reset_i && (!m_reg_v || mem_cmd_yumi) && exp_q.size() < MAX) begin
      for (int i = 0; i < N; i++) begin
        if (w < 0 && cmd_v[TW'((m_ptr + i) % N)]) w = (m_ptr + i) % N;
      end
    end
    e_yumi = '0;
    if (w >= 0) e_yumi[TW'(w)] = 1'b1;
    e_rv  = '0;
    e_rdy = 1'b0;
    if (exp_q.size() > 0) begin
      if (mem_resp_v) e_rv[exp_q[0]] = 1'b1;
      e_rdy = resp_ready[exp_q[0]];
    end
    check("cmd_yumi", 64'(cmd_yumi), 64'(e_yumi));
    check("mem_cmd_v", 64'(mem_cmd_v), 64'(m_reg_v));
    check("mem_cmd", 64'(mem_cmd), 64'(m_reg_d));
    check("outstanding", 64'(outstanding), 64'(exp_q.size()));
    check("resp_v", 64'(resp_v), 64'(e_rv));
    check("mem_resp_ready", 64'(mem_resp_ready), 64'(e_rdy));
    check("resp_o", resp, {N{mem_resp}});
    check("error", 64'(error), 64'(m_err));
    fire = mem_resp_v && e_rdy;
    @(posedge clk_i);
    if (reset_i) model_reset();
    else begin
      if (mem_resp_v && exp_q.size() == 0) m_err = 1;
      if (fire) void'(exp_q.pop_front());
      if (mem_cmd_yumi) m_reg_v = 0;
      if (w >= 0) begin
        m_reg_v = 1;
        m_reg_d = cmd[w*CW +: CW];
        exp_q.push_back(TW'(w));
        m_ptr = (w + 1) % N;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      drive('0, 1'b1, '1);
      step();
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    b_cmd   = '0;
    b_cmd_v = '0;
    model_reset();
    reset_i = 1'b1;
    drive('1, 1'b0, '0);
    @(negedge clk_i);
    step();
    step();
    reset_i = 1'b0;

    // Single request from channel 0, then its response.
    drive(4'b0001, 1'b0, '0);
    cmd[CW-1:0] = 16'h00A5;
    step();
    drive('0, 1'b0, '0);
    step();
    drive('0, 1'b1, '1);
    mem_resp = 16'h0077;
    step();
    drive('0, 1'b0, '0);
    step();

    // All channels requesting with responses flowing: rotating grants.
    for (int k = 0; k < 10; k++) begin
      drive('1, exp_q.size() > 0, '1);
      step();
    end
    drain();

    // Outstanding limit with no responses, then a single pop.
    for (int k = 0; k < 6; k++) begin
      drive('1, 1'b0, '0);
      step();
    end
    drive('1, 1'b1, '1);
    step();
    for (int k = 0; k < 3; k++) begin
      drive('1, 1'b0, '0);
      step();
    end
    drain();

    // Routing and backpressure: issue ch2 then ch0.
    drive(4'b0100, 1'b0, '0);
    step();
    drive(4'b0001, 1'b0, '0);
    step();
    drive('0, 1'b1, 4'b0000);
    step();
    drive('0, 1'b1, 4'b1011);
    step();
    drive('0, 1'b1, 4'b0100);
    step();
    drive('0, 1'b1, 4'b0001);
    step();

    // Downstream stall for five cycles, then a yumi.
    drive(4'b0010, 1'b0, '0);
    step();
    for (int k = 0; k < 5; k++) begin
      drive('1, 1'b0, '0);
      mem_cmd_yumi = 1'b0;
      step();
    end
    drive('1, 1'b0, '0);
    step();
    drain();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      drive(N'($urandom_range(0, 15)), (exp_q.size() > 0) && ($urandom_range(0, 2) != 0),
            N'($urandom_range(0, 15)));
      mem_cmd_yumi = m_reg_v && ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Response with nothing outstanding sets the sticky error.
    drive('0, 1'b1, '1);
    step();
    drive('0, 1'b0, '1);
    step();
    drive('0, 1'b0, '0);
    step();

    // Asynchronous reset in the middle of a cycle with traffic in flight.
    for (int k = 0; k < 2; k++) begin
      drive('1, 1'b0, '1);
      step();
    end
    drive('1, 1'b1, '1);
    #3 reset_i = 1'b1;
    #1;
    check("rst_mem_cmd_v", 64'(mem_cmd_v), 64'd0);
    check("rst_mem_cmd", 64'(mem_cmd), 64'd0);
    check("rst_cmd_yumi", 64'(cmd_yumi), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_resp_v", 64'(resp_v), 64'd0);
    check("rst_mem_resp_ready", 64'(mem_resp_ready), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    model_reset();
    @(negedge clk_i);
    drive('1, 1'b0, '0);
    step();
    reset_i = 1'b0;
    drive(4'b1000, 1'b0, '0);
    step();
    drive('0, 1'b0, '0);
    step();
    drain();

    // Fixed priority: lowest index wins every time until the limit of four.
    cmd_v   = '0;
    b_cmd_v = '1;
    b_cmd   = {$urandom};
    for (int k = 0; k < 5; k++) begin
      #1;
      check("fixed_grant", 64'(b_cmd_yumi), (k < 4) ? 64'd1 : 64'd0);
      @(negedge clk_i);
    end
    check("fixed_outstanding", 64'(b_outstanding), 64'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
